// File: rtl/spec_pkg.sv
// spec_pkg: shared speculation-ID types, sizes and squash-mask helper
package spec_pkg;
  localparam int SPEC_ID_W = 5;
  localparam int SPEC_NUM_IDS = 32;
  typedef logic [SPEC_ID_W-1:0] spec_id_t;
  function automatic logic [SPEC_NUM_IDS-1:0] spec_onehot(input spec_id_t id);
    return {{(SPEC_NUM_IDS-1){1'b0}}, 1'b1} << id;
  endfunction
  function automatic logic [SPEC_NUM_IDS-1:0] spec_squash_mask(input spec_id_t id);
    return {SPEC_NUM_IDS{1'b1}} << id;
  endfunction
endpackage

// File: rtl/spec_oldest_finder.sv
// spec_oldest_finder: lowest-set-bit priority encoder over the live bitmap
// vec in: bitmap; valid out: any bit set; idx out: index of lowest set bit
module spec_oldest_finder
  import spec_pkg::*;
(
  input  logic [SPEC_NUM_IDS-1:0] vec,
  output logic                    valid,
  output spec_id_t                idx
);
  always_comb begin
    idx = '0;
    for (int i = SPEC_NUM_IDS - 1; i >= 0; i--) idx = vec[i] ? spec_id_t'(i) : idx;
    valid = |vec;
  end
endmodule

// File: rtl/spec_tag_alloc.sv
// spec_tag_alloc: monotonically increasing speculation-tag allocator with squash broadcast
// clk/rst (async, active-low); br_valid/br_ready/br_tag: tag request handshake;
// res_valid/res_id/res_mispredict: resolutions; new_spec_valid/new_spec_id: registered grant;
// invalid/miss_id: registered squash pulse; count: outstanding tags.
// SPEC_ALLOC_OLDEST_EN adds registered oldest_valid/oldest_id (lowest live ID).
module spec_tag_alloc
  import spec_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     br_valid,
  output logic     br_ready,
  output spec_id_t br_tag,
  input  logic     res_valid,
  input  spec_id_t res_id,
  input  logic     res_mispredict,
  output logic     new_spec_valid,
  output spec_id_t new_spec_id,
  output logic     invalid,
  output spec_id_t miss_id,
  output logic [5:0] count
`ifdef SPEC_ALLOC_OLDEST_EN
  ,
  output logic     oldest_valid,
  output spec_id_t oldest_id
`endif
);
  localparam logic [SPEC_ID_W:0] EXHAUSTED = (SPEC_ID_W + 1)'(SPEC_NUM_IDS);
  logic [SPEC_NUM_IDS-1:0] live, live_n;
  logic [SPEC_ID_W:0] next_id, next_id_n;
  logic [5:0] count_n;
  logic acc, res_live, good, squash, drained;
  assign br_ready = (int'(count) < DEPTH) && (next_id != EXHAUSTED) && !invalid;
  assign br_tag = next_id[SPEC_ID_W-1:0];
  always_comb begin
    acc = br_valid && br_ready;
    res_live = live[res_id];
    good = res_valid && !res_mispredict && res_live;
    squash = res_valid && res_mispredict && res_live;
    // IDs restart only once every outstanding tag has drained, so unsigned compares stay valid
    drained = (next_id == EXHAUSTED) && (count == '0);
    // a same-cycle accepted tag is always >= res_id, so the squash mask removes it too
    live_n = (live | (acc ? spec_onehot(br_tag) : '0))
           & ~(good ? spec_onehot(res_id) : '0)
           & ~(squash ? spec_squash_mask(res_id) : '0);
    next_id_n = squash ? {1'b0, res_id} : drained ? '0 : acc ? next_id + 1'b1 : next_id;
    count_n = 6'($countones(live_n));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live <= '0;
      next_id <= '0;
      count <= '0;
      new_spec_valid <= 1'b0;
      new_spec_id <= '0;
      invalid <= 1'b0;
      miss_id <= '0;
    end else begin
      live <= live_n;
      next_id <= next_id_n;
      count <= count_n;
      new_spec_valid <= acc;
      new_spec_id <= br_tag;
      invalid <= squash;
      miss_id <= squash ? res_id : miss_id;
    end
  end
`ifdef SPEC_ALLOC_OLDEST_EN
  logic old_v;
  spec_id_t old_i;
  spec_oldest_finder u_finder (
    .vec  (live_n),
    .valid(old_v),
    .idx  (old_i)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oldest_valid <= 1'b0;
      oldest_id <= '0;
    end else begin
      oldest_valid <= old_v;
      oldest_id <= old_i;
    end
  end
`endif
endmodule
